// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// funct3 values, ALU control codes and datapath mux selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_WORD = 3'b010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;

   localparam logic [1:0] RES_ALUOUT  = 2'b00;
   localparam logic [1:0] RES_MEMDATA = 2'b01;
   localparam logic [1:0] RES_ALU     = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   // funct3 values the ALU path supports for both R- and I-type
   function automatic logic alu_f3_ok(input logic [2:0] f3);
      return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_OR) || (f3 == F3_AND);
   endfunction

endpackage

// File: rtl/ctrl_alu_decoder.sv
// Combinational ALU-operation decode from opcode, funct3 and instr[30].
module ctrl_alu_decoder
   import ctrl_pkg::*;
#(
   parameter int OPCODE_WIDTH  = 7,
   parameter int ALUCTRL_WIDTH = 3
) (
   input  logic [OPCODE_WIDTH-1:0]  opcode,
   input  logic [2:0]               funct3,
   input  logic                     funct7b5,
   output logic [ALUCTRL_WIDTH-1:0] alu_ctrl
);

   logic [2:0] op;

   always_comb begin
      op = ALU_ADD;
      case (funct3)
         // instr[30] only selects subtract for register-register ops
         F3_ADD: if (opcode == OPCODE_WIDTH'(OP_RTYPE) && funct7b5) op = ALU_SUB;
         F3_AND: op = ALU_AND;
         F3_OR:  op = ALU_OR;
         F3_SLT: op = ALU_SLT;
         default: op = ALU_ADD;
      endcase
   end

   assign alu_ctrl = ALUCTRL_WIDTH'(op);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32 subset control FSM. Define CTRL_MEM_WAIT_EN to make FETCH,
// MEMREAD and MEMWRITE wait for mem_ready; otherwise every state is one cycle.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int OPCODE_WIDTH  = 7,
   parameter int ALUCTRL_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [31:0]              instr,
   input  logic                     zero,
   input  logic                     mem_ready,
   output logic                     pc_write,
   output logic                     ir_write,
   output logic                     reg_write,
   output logic                     mem_write,
   output logic                     adr_src,
   output logic [1:0]               alu_src_a,
   output logic [1:0]               alu_src_b,
   output logic [1:0]               result_src,
   output logic [2:0]               imm_src,
   output logic [ALUCTRL_WIDTH-1:0] alu_ctrl,
   output logic                     retire,
   output logic                     illegal
);

   state_t                    state, state_next;
   logic [OPCODE_WIDTH-1:0]   opcode;
   logic [2:0]                funct3;
   logic [ALUCTRL_WIDTH-1:0]  alu_op;
   logic                      mem_done;
   logic                      unused_bits;

   assign opcode      = instr[OPCODE_WIDTH-1:0];
   assign funct3      = instr[14:12];
   assign unused_bits = ^{instr, mem_ready};

`ifdef CTRL_MEM_WAIT_EN
   assign mem_done = mem_ready;
`else
   assign mem_done = 1'b1;
`endif

   ctrl_alu_decoder #(
      .OPCODE_WIDTH  (OPCODE_WIDTH),
      .ALUCTRL_WIDTH (ALUCTRL_WIDTH)
   ) u_alu_decoder (
      .opcode   (opcode),
      .funct3   (funct3),
      .funct7b5 (instr[30]),
      .alu_ctrl (alu_op)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_RS2;
      result_src = RES_ALUOUT;
      imm_src    = IMM_I;
      alu_ctrl   = '0;
      retire     = 1'b0;
      illegal    = 1'b0;

      case (state)
         S_FETCH: begin
            ir_write   = mem_done;
            pc_write   = mem_done;
            alu_src_a  = SRCA_PC;
            alu_src_b  = SRCB_FOUR;
            alu_ctrl   = ALUCTRL_WIDTH'(ALU_ADD);
            result_src = RES_ALU;
            state_next = mem_done ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_IMM;
            alu_ctrl   = ALUCTRL_WIDTH'(ALU_ADD);
            state_next = S_TRAP;
            case (opcode)
               OPCODE_WIDTH'(OP_LOAD): begin
                  imm_src = IMM_I;
                  if (funct3 == F3_WORD) state_next = S_MEMADR;
               end
               OPCODE_WIDTH'(OP_STORE): begin
                  imm_src = IMM_S;
                  if (funct3 == F3_WORD) state_next = S_MEMADR;
               end
               OPCODE_WIDTH'(OP_RTYPE): begin
                  if (alu_f3_ok(funct3)) state_next = S_EXECR;
               end
               OPCODE_WIDTH'(OP_ITYPE): begin
                  imm_src = IMM_I;
                  if (alu_f3_ok(funct3)) state_next = S_EXECI;
               end
               OPCODE_WIDTH'(OP_BRANCH): begin
                  imm_src = IMM_B;
                  if (funct3 == F3_BEQ || funct3 == F3_BNE) state_next = S_BRANCH;
               end
               OPCODE_WIDTH'(OP_JAL): begin
                  imm_src    = IMM_J;
                  state_next = S_JAL;
               end
               default: state_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_ctrl   = ALUCTRL_WIDTH'(ALU_ADD);
            state_next = (opcode == OPCODE_WIDTH'(OP_STORE)) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            adr_src    = 1'b1;
            state_next = mem_done ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            result_src = RES_MEMDATA;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_src    = 1'b1;
            mem_write  = 1'b1;
            retire     = mem_done;
            state_next = mem_done ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_ctrl   = alu_op;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_IMM;
            alu_ctrl   = alu_op;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            retire     = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a  = SRCA_RS1;
            alu_src_b  = SRCB_RS2;
            alu_ctrl   = ALUCTRL_WIDTH'(ALU_SUB);
            result_src = RES_ALUOUT;
            retire     = 1'b1;
            pc_write   = ((funct3 == F3_BEQ) && zero) || ((funct3 == F3_BNE) && !zero);
            state_next = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = SRCA_OLDPC;
            alu_src_b  = SRCB_FOUR;
            alu_ctrl   = ALUCTRL_WIDTH'(ALU_ADD);
            result_src = RES_ALUOUT;
            pc_write   = 1'b1;
            state_next = S_ALUWB;
         end
         S_TRAP: begin
            illegal    = 1'b1;
            state_next = S_TRAP;
         end
         default: state_next = S_FETCH;
      endcase

      // state already reads FETCH during reset; its write strobes must stay quiet
      if (!rst_n) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         retire    = 1'b0;
         illegal   = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomised self-checking bench: each instruction is expanded into its list of
// per-cycle control words and compared against the DUT outputs every cycle.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] instr = '0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic        pc_write, ir_write, reg_write, mem_write, adr_src;
   logic [1:0]  alu_src_a, alu_src_b, result_src;
   logic [2:0]  imm_src, alu_ctrl;
   logic        retire, illegal;
   logic [18:0] obs;

   multicycle_control_unit #(
      .OPCODE_WIDTH  (7),
      .ALUCTRL_WIDTH (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .instr      (instr),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .ir_write   (ir_write),
      .reg_write  (reg_write),
      .mem_write  (mem_write),
      .adr_src    (adr_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .imm_src    (imm_src),
      .alu_ctrl   (alu_ctrl),
      .retire     (retire),
      .illegal    (illegal)
   );

   always #5 clk = ~clk;

   assign obs = {pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a, alu_src_b,
                 result_src, imm_src, alu_ctrl, retire, illegal};

   typedef enum int {C_LW, C_SW, C_R, C_I, C_BR, C_JAL, C_ILL} cls_t;

   // br: 0 none, 1 pc_write follows zero, 2 pc_write follows !zero; mem: memory-wait step
   typedef struct {
      string       name;
      logic [18:0] vec;
      int          br;
      bit          mem;
   } step_t;

   step_t steps[$];
   int    n_vec = 0;
   int    n_miss = 0;
   int    zero_force = -1;

   function automatic logic [18:0] mk(input int pc, ir, rw, mw, adr, a, b, res, imm, alu, ret, ill);
      return {1'(pc), 1'(ir), 1'(rw), 1'(mw), 1'(adr), 2'(a), 2'(b), 2'(res), 3'(imm), 3'(alu),
              1'(ret), 1'(ill)};
   endfunction

   localparam logic [18:0] RST_VEC = 19'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10,
                                          3'b000, 3'b000, 1'b0, 1'b0});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // expected control words, one per cycle, for an instruction of class c
   function automatic void plan(input cls_t c, input int imm, input int alu, input int br);
      steps.delete();
      steps.push_back('{"FETCH", mk(1, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0), 0, 1'b1});
      steps.push_back('{"DECODE", mk(0, 0, 0, 0, 0, 1, 1, 0, imm, 0, 0, 0), 0, 1'b0});
      case (c)
         C_LW: begin
            steps.push_back('{"MEMADR", mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0), 0, 1'b0});
            steps.push_back('{"MEMREAD", mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 0, 1'b1});
            steps.push_back('{"MEMWB", mk(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0), 0, 1'b0});
         end
         C_SW: begin
            steps.push_back('{"MEMADR", mk(0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0), 0, 1'b0});
            steps.push_back('{"MEMWRITE", mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0), 0, 1'b1});
         end
         C_R: begin
            steps.push_back('{"EXECR", mk(0, 0, 0, 0, 0, 2, 0, 0, 0, alu, 0, 0), 0, 1'b0});
            steps.push_back('{"ALUWB", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 1'b0});
         end
         C_I: begin
            steps.push_back('{"EXECI", mk(0, 0, 0, 0, 0, 2, 1, 0, 0, alu, 0, 0), 0, 1'b0});
            steps.push_back('{"ALUWB", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 1'b0});
         end
         C_BR: begin
            steps.push_back('{"BRANCH", mk(0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 1, 0), br, 1'b0});
         end
         C_JAL: begin
            steps.push_back('{"JAL", mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0), 0, 1'b0});
            steps.push_back('{"ALUWB", mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0), 0, 1'b0});
         end
         default: begin
            for (int i = 0; i < 4; i++)
               steps.push_back('{"TRAP", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 0, 1'b0});
         end
      endcase
   endfunction

   // one cycle (plus any memory wait cycles); entered and left on a falling edge
   task automatic do_step(input step_t s);
      int          stalls = 0;
      bit          hold;
      logic [18:0] exp;
      do begin
         zero      = (zero_force < 0) ? 1'($urandom) : 1'(zero_force);
         mem_ready = (stalls >= 5) ? 1'b1 : 1'($urandom);
         #1;
         exp = s.vec;
         if (s.br == 1) exp[18] = zero;
         else if (s.br == 2) exp[18] = !zero;
         hold = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
         if (s.mem && !mem_ready) begin
            hold    = 1'b1;
            exp[18] = 1'b0;
            exp[17] = 1'b0;
            exp[1]  = 1'b0;
         end
`endif
         check(s.name, 32'(obs), 32'(exp));
         stalls++;
         @(negedge clk);
      end while (hold);
   endtask

   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 check(tag, 32'(obs), 32'(RST_VEC));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_instr(input logic [31:0] ins, input cls_t c, input int imm, input int alu,
                            input int br);
      plan(c, imm, alu, br);
      instr = ins;
      foreach (steps[i]) do_step(steps[i]);
      if (c == C_ILL) pulse_reset("trap.reset");
   endtask

   function automatic bit legal_op(input logic [6:0] op);
      return op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111};
   endfunction

   task automatic run_random();
      int          k = $urandom_range(0, 7);
      int          idx;
      int          alu;
      logic [31:0] r = $urandom;
      logic [2:0]  f3;
      logic [2:0]  bad_alu [4];
      logic        b30;
      logic [6:0]  op;
      bad_alu = '{3'b001, 3'b011, 3'b100, 3'b101};
      b30 = r[30];
      case (k)
         0: run_instr({r[31:20], r[19:15], 3'b010, r[11:7], 7'b0000011}, C_LW, 0, 0, 0);
         1: run_instr({r[31:25], r[24:20], r[19:15], 3'b010, r[11:7], 7'b0100011}, C_SW, 1, 0, 0);
         2: begin
            idx = $urandom_range(0, 4);
            case (idx)
               0: begin f3 = 3'b000; b30 = 1'b0; alu = 0; end
               1: begin f3 = 3'b000; b30 = 1'b1; alu = 1; end
               2: begin f3 = 3'b010; alu = 5; end
               3: begin f3 = 3'b110; alu = 3; end
               default: begin f3 = 3'b111; alu = 2; end
            endcase
            run_instr({1'b0, b30, 5'b0, r[24:20], r[19:15], f3, r[11:7], 7'b0110011}, C_R, 0, alu, 0);
         end
         3: begin
            idx = $urandom_range(0, 3);
            case (idx)
               0: begin f3 = 3'b000; alu = 0; end
               1: begin f3 = 3'b010; alu = 5; end
               2: begin f3 = 3'b110; alu = 3; end
               default: begin f3 = 3'b111; alu = 2; end
            endcase
            run_instr({r[31:20], r[19:15], f3, r[11:7], 7'b0010011}, C_I, 0, alu, 0);
         end
         4: run_instr({r[31:25], r[24:20], r[19:15], 2'b00, r[0], r[11:7], 7'b1100011}, C_BR, 2, 1,
                      r[0] ? 2 : 1);
         5: run_instr({r[31:12], r[11:7], 7'b1101111}, C_JAL, 3, 0, 0);
         6: begin
            op = r[6:0];
            while (legal_op(op)) op = 7'($urandom);
            run_instr({r[31:7], op}, C_ILL, 0, 0, 0);
         end
         default: begin
            idx = $urandom_range(0, 3);
            case (idx)
               0: run_instr({r[31:15], bad_alu[$urandom_range(0, 3)], r[11:7], 7'b0110011}, C_ILL, 0, 0, 0);
               1: run_instr({r[31:15], bad_alu[$urandom_range(0, 3)], r[11:7], 7'b0010011}, C_ILL, 0, 0, 0);
               2: run_instr({r[31:15], 3'($urandom_range(2, 7)), r[11:7], 7'b1100011}, C_ILL, 2, 0, 0);
               default: begin
                  f3 = 3'($urandom);
                  while (f3 == 3'b010) f3 = 3'($urandom);
                  if (r[1]) run_instr({r[31:15], f3, r[11:7], 7'b0100011}, C_ILL, 1, 0, 0);
                  else      run_instr({r[31:15], f3, r[11:7], 7'b0000011}, C_ILL, 0, 0, 0);
               end
            endcase
         end
      endcase
   endtask

   initial begin
      @(negedge clk);
      mem_ready = 1'($urandom);
      #1 check("reset", 32'(obs), 32'(RST_VEC));
      @(negedge clk);
      rst_n = 1'b1;

      run_instr(32'h00500093, C_I, 0, 0, 0);    // addi x1,x0,5
      run_instr(32'h0000A103, C_LW, 0, 0, 0);   // lw x2,0(x1)
      run_instr(32'h40208033, C_R, 0, 1, 0);    // sub x0,x1,x2
      run_instr(32'h0020F033, C_R, 0, 2, 0);    // and x0,x1,x2
      run_instr(32'h0020A223, C_SW, 1, 0, 0);   // sw x2,4(x1)
      zero_force = 0;
      run_instr(32'h00209463, C_BR, 2, 1, 2);   // bne, not equal: taken
      zero_force = 1;
      run_instr(32'h00209463, C_BR, 2, 1, 2);   // bne, equal: not taken
      zero_force = -1;
      run_instr(32'h008000EF, C_JAL, 3, 0, 0);  // jal x1,8

      // reset dropped while a store is in MEMWRITE
      plan(C_SW, 1, 0, 0);
      instr = 32'h0020A223;
      for (int i = 0; i < 3; i++) do_step(steps[i]);
      mem_ready = 1'b0;
      #1 check("sw.MEMWRITE.mem_write", 32'(mem_write), 32'd1);
      #2 rst_n = 1'b0;
      #1 check("sw.midreset", 32'(obs), 32'(RST_VEC));
      @(negedge clk);
      rst_n = 1'b1;

      run_instr(32'h0000007F, C_ILL, 0, 0, 0);  // unknown opcode traps until reset

      for (int n = 0; n < 200; n++) run_random();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
